uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver for the peripheral subsystem; the receive-side counterpart of the existing baud-timed transmit path.
- Oversamples the asynchronous serial line rx_i with the system clock and validates the start bit at half-bit.
- Samples data bits LSB-first at bit centres and checks the stop bit.
- Presents each received byte on a valid/ready interface to the core bus, with framing-error and overrun flags.

Parameters:
- CLOCK, 100e6: system clock frequency in Hz.
- BAUD_RATE, 20000000: line rate in bit/s.
- CLKS_PER_BIT, CLOCK/BAUD_RATE (integer): clocks per bit; must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer division): start-bit validation delay.
- DATA_BITS, 8: data bits per frame; 5..8 legal.
- CW, $clog2(CLKS_PER_BIT+1): width of the bit-timing counter.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- rx_i  in  1  serial line, asynchronous to clk_i; idle high.
- rx_data_o  out  DATA_BITS  received byte; stable while rx_valid_o=1.
- rx_valid_o  out  1  byte available.
- rx_ready_i  in  1  consumer accepts the byte when rx_valid_o and rx_ready_i are both 1.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled 0.
- overrun_err_o  out  1  one-cycle pulse: byte completed while the previous byte was still held.
- busy_o  out  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=IDLE, counter=0, bit index=0, shift register=0.
  - Both synchronizer flops=1, so the line reads as idle.
  - rx_data_o=0; rx_valid_o, frame_err_o, overrun_err_o, busy_o all 0.
  - Reset asserted mid-frame aborts the frame. After release the FSM waits in IDLE for a fresh falling edge.
- Input synchronizer: two flops on rx_i produce rx_s. The FSM uses only rx_s, giving a fixed 2-cycle delay from rx_i.
- FSM states and transitions:
  - IDLE: if rx_s=0, go to START with counter=0.
  - START: counter increments each cycle. When counter=HALF_BIT-1, check rx_s:
    - rx_s=0: go to DATA with counter=0 and bit index=0.
    - rx_s=1: glitch; return to IDLE with no flags.
  - DATA: when counter=CLKS_PER_BIT-1, shift rx_s into the shift register (LSB first), clear counter and increment bit index. After DATA_BITS samples, go to STOP with counter=0. Otherwise counter increments.
  - STOP: when counter=CLKS_PER_BIT-1, sample rx_s:
    - rx_s=1: deliver the byte, then go to IDLE.
    - rx_s=0: pulse frame_err_o, discard the byte, go to BREAK.
  - BREAK: stay until rx_s=1, then go to IDLE. This prevents a held-low line from retriggering reception.
- Timing:
  - Let t0 be the clock edge at which IDLE samples rx_s=0.
  - The stop sample occurs at edge t0 + HALF_BIT + (DATA_BITS+1)*CLKS_PER_BIT.
  - rx_valid_o, frame_err_o and overrun_err_o are registered and rise 1 cycle after the stop sample.
  - A back-to-back frame whose start edge arrives immediately after the stop-bit centre is received correctly, since IDLE is re-entered at the stop-bit centre.
- Delivery:
  - If rx_valid_o=0, or (rx_valid_o=1 and rx_ready_i=1) in the delivery cycle: load rx_data_o and keep/set rx_valid_o=1.
  - If rx_valid_o=1 and rx_ready_i=0: the new byte is dropped, the old rx_data_o is kept, and overrun_err_o pulses.
- Handshake:
  - rx_valid_o clears on the cycle after a handshake, unless a delivery happens in the same cycle.
  - rx_data_o never changes while rx_valid_o=1 without a handshake.
- frame_err_o and overrun_err_o are never both 1 in the same cycle.
- Counter width is CW bits. Counters never wrap: the FSM always clears them at terminal count.

Test Plan:
1. Reset and idle: hold rx_i=1 for 200 cycles after reset release, CLKS_PER_BIT=10 → all outputs 0, busy_o=0.
2. Single byte: send 0xA5 (start=0, bits LSB-first, stop=1, 10 clocks/bit), rx_ready_i=0 → rx_valid_o rises at t0+96 with rx_data_o=0xA5. It stays high until rx_ready_i is pulsed, then falls the next cycle.
3. Glitch rejection: drive rx_i low for 3 cycles (< HALF_BIT=5 after sync), then high → FSM returns to IDLE, no valid, no error, busy_o low again within 6 cycles.
4. Framing error: send 0x3C with stop bit=0, then hold rx_i low for 50 cycles, then high → frame_err_o pulses once, rx_valid_o stays 0. No new reception starts until the line goes high and a new start bit arrives.
5. Overrun: send 0x11 then 0x22 back-to-back, rx_ready_i=0 → rx_data_o=0x11 retained, overrun_err_o pulses once at the 0x22 stop sample + 1.
6. Streaming: send 0x00, 0xFF, 0x55 back-to-back with rx_ready_i=1 constantly → three single-cycle rx_valid_o pulses carrying 0x00, 0xFF, 0x55, no errors. Also assert rst_ni low during the second frame → outputs clear immediately and the next frame is received cleanly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: oversamples rx_i, validates the start bit at half-bit, samples
// LSB-first data at bit centres and hands each byte out on a valid/ready port.
module uart_rx #(
    parameter int CLOCK        = 100_000_000,
    parameter int BAUD_RATE    = 20_000_000,
    parameter int CLKS_PER_BIT = CLOCK / BAUD_RATE,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2,
    parameter int DATA_BITS    = 8,
    parameter int CW           = $clog2(CLKS_PER_BIT + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_err_o,
    output logic                 busy_o
);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 sync1_q, rx_s_q;
    logic                 deliver_q, deliver_d;
    logic                 fe_pend_q, fe_pend_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q;
    logic                 ovr_q, ovr_d;

    // Synchronizer resets to 1 so the line reads idle straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            deliver_q <= 1'b0;
            fe_pend_q <= 1'b0;
        end else begin
            sync1_q   <= rx_i;
            rx_s_q    <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            deliver_q <= deliver_d;
            fe_pend_q <= fe_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        deliver_d = 1'b0;
        fe_pend_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + BW'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                // Back to IDLE at the stop-bit centre so a back-to-back start edge is caught.
                if (cnt_q == CNT_BIT) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        deliver_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        fe_pend_d = 1'b1;
                        state_d   = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Delivery: a new byte only replaces the held one if it is being consumed now.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end
        if (deliver_q) begin
            if (!valid_q || rx_ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= fe_pend_q;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data_o     = data_q;
    assign rx_valid_o    = valid_q;
    assign frame_err_o   = ferr_q;
    assign overrun_err_o = ovr_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 10 clocks/bit: directed scenarios plus randomized frames,
// glitches and ready patterns, all compared per cycle against a frame-level model.
module tb_uart_rx;
    localparam int C  = 10;
    localparam int H  = C / 2;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          rx_i = 1'b1;
    logic          rx_ready_i = 1'b0;
    logic [DB-1:0] rx_data_o;
    logic          rx_valid_o;
    logic          frame_err_o;
    logic          overrun_err_o;
    logic          busy_o;

    uart_rx #(
        .CLOCK    (100_000_000),
        .BAUD_RATE(10_000_000),
        .DATA_BITS(DB)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .rx_i         (rx_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .frame_err_o  (frame_err_o),
        .overrun_err_o(overrun_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame events: posedge number at which the outcome becomes visible.
    int            ev_edge [256];
    logic          ev_ok   [256];
    logic [DB-1:0] ev_data [256];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    logic          m_valid = 1'b0;
    logic          m_fe = 1'b0;
    logic          m_ov = 1'b0;
    logic [DB-1:0] m_data = '0;
    int            mk;
    logic          mv;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_fe    <= 1'b0;
            m_ov    <= 1'b0;
            rd_ptr  <= wr_ptr;
        end else begin
            mk = cyc + 1;
            mv = m_valid;
            m_fe <= 1'b0;
            m_ov <= 1'b0;
            if (m_valid && rx_ready_i) mv = 1'b0;
            if (rd_ptr != wr_ptr && ev_edge[rd_ptr % 256] == mk) begin
                rd_ptr <= rd_ptr + 1;
                if (!ev_ok[rd_ptr % 256]) begin
                    m_fe <= 1'b1;
                end else if (!m_valid || rx_ready_i) begin
                    m_data <= ev_data[rd_ptr % 256];
                    mv = 1'b1;
                end else begin
                    m_ov <= 1'b1;
                end
            end
            m_valid <= mv;
        end
    end

    int   n_chk = 0;
    int   n_err = 0;
    logic rdy_val = 1'b0;
    logic rdy_rand = 1'b0;
    int   vrise = 0, vhigh = 0, fcnt = 0, ocnt = 0;
    int   vrise_cyc = 0, f_cyc = 0, o_cyc = 0;
    logic [DB-1:0] vlog [16];
    logic pv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic line(input logic b, input int n);
        rx_i = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop, output int e1);
        e1 = cyc + 1;
        ev_edge[wr_ptr % 256] = e1 + 3 + H + (DB + 1) * C;
        ev_ok[wr_ptr % 256]   = stop;
        ev_data[wr_ptr % 256] = d;
        wr_ptr = wr_ptr + 1;
        line(1'b0, C);
        for (int i = 0; i < DB; i++) line(d[i], C);
        line(stop, C);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, rx_valid_o, 0);
        check({tag, "_data"}, rx_data_o, 0);
        check({tag, "_ferr"}, frame_err_o, 0);
        check({tag, "_ovr"}, overrun_err_o, 0);
        check({tag, "_busy"}, busy_o, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e1, e2, s, sf, so, sh, w, g, kind;
        logic [DB-1:0] d;
        logic st;

        fork
            forever begin
                @(posedge clk);
                #2;
                rx_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
            end
            forever begin
                @(negedge clk);
                check("valid", rx_valid_o, m_valid);
                check("data", rx_data_o, m_data);
                check("frame_err", frame_err_o, m_fe);
                check("overrun", overrun_err_o, m_ov);
                check("err_excl", frame_err_o & overrun_err_o, 0);
                if (rx_valid_o && !pv) begin
                    vlog[vrise & 15] = rx_data_o;
                    vrise++;
                    vrise_cyc = cyc;
                end
                if (rx_valid_o) vhigh++;
                if (frame_err_o) begin fcnt++; f_cyc = cyc; end
                if (overrun_err_o) begin ocnt++; o_cyc = cyc; end
                pv = rx_valid_o;
            end
        join_none

        repeat (5) @(negedge clk);
        check_idle_outputs("reset");
        rst_ni = 1'b1;
        repeat (200) @(negedge clk);
        check_idle_outputs("idle200");

        // Single byte held until ready pulses.
        send_frame(8'hA5, 1'b1, e1);
        check("a5_rise_time", vrise_cyc, (e1 + 2) + 96);
        check("a5_valid", rx_valid_o, 1);
        check("a5_data", rx_data_o, 8'hA5);
        repeat (20) @(negedge clk);
        check("a5_hold", rx_valid_o, 1);
        rdy_val = 1'b1;
        @(negedge clk);
        rdy_val = 1'b0;
        repeat (3) @(negedge clk);
        check("a5_cleared", rx_valid_o, 0);
        check("a5_data_kept", rx_data_o, 8'hA5);

        // Short low glitch is rejected.
        s = vrise; sf = fcnt;
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        check("glitch_busy", busy_o, 1);
        repeat (5) @(negedge clk);
        check("glitch_idle", busy_o, 0);
        repeat (20) @(negedge clk);
        check("glitch_novalid", vrise - s, 0);
        check("glitch_noferr", fcnt - sf, 0);

        // Framing error followed by a held-low line.
        s = vrise; sf = fcnt;
        send_frame(8'h3C, 1'b0, e1);
        repeat (50) @(negedge clk);
        check("ferr_once", fcnt - sf, 1);
        check("ferr_time", f_cyc, e1 + 98);
        check("break_busy", busy_o, 1);
        rx_i = 1'b1;
        repeat (5) @(negedge clk);
        check("break_exit", busy_o, 0);
        check("ferr_novalid", vrise - s, 0);

        // Overrun: second byte dropped while first is held.
        so = ocnt;
        send_frame(8'h11, 1'b1, e1);
        send_frame(8'h22, 1'b1, e2);
        repeat (5) @(negedge clk);
        check("ovr_once", ocnt - so, 1);
        check("ovr_time", o_cyc, e2 + 98);
        check("ovr_data", rx_data_o, 8'h11);
        check("ovr_valid", rx_valid_o, 1);
        rdy_val = 1'b1;
        repeat (5) @(negedge clk);

        // Streaming with ready held high.
        s = vrise; sh = vhigh; sf = fcnt; so = ocnt;
        send_frame(8'h00, 1'b1, e1);
        send_frame(8'hFF, 1'b1, e1);
        send_frame(8'h55, 1'b1, e1);
        repeat (5) @(negedge clk);
        check("stream_count", vrise - s, 3);
        check("stream_pulses", vhigh - sh, 3);
        check("stream_b0", vlog[s & 15], 8'h00);
        check("stream_b1", vlog[(s + 1) & 15], 8'hFF);
        check("stream_b2", vlog[(s + 2) & 15], 8'h55);
        check("stream_noerr", (fcnt - sf) + (ocnt - so), 0);

        // Reset mid-frame while a byte is held.
        rdy_val = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(8'h96, 1'b1, e1);
        line(1'b0, C);
        line(1'b1, 3 * C);
        check("pre_rst_valid", rx_valid_o, 1);
        check("pre_rst_busy", busy_o, 1);
        #3 rst_ni = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        repeat (20) @(negedge clk);
        #3 rst_ni = 1'b1;
        @(negedge clk);
        rdy_val = 1'b1;
        repeat (3) @(negedge clk);
        s = vrise;
        send_frame(8'h55, 1'b1, e1);
        repeat (5) @(negedge clk);
        check("post_rst_count", vrise - s, 1);
        check("post_rst_data", vlog[s & 15], 8'h55);

        // Randomized frames, glitches, framing errors and ready patterns.
        rdy_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                w = $urandom_range(1, 4);
                line(1'b0, w);
                line(1'b1, C);
            end else begin
                d  = DB'($urandom);
                st = (kind != 1);
                send_frame(d, st, e1);
                g = st ? $urandom_range(0, 12) : $urandom_range(2, 12);
                if (g > 0) line(1'b1, g);
            end
        end
        rx_i = 1'b1;
        rdy_rand = 1'b0;
        rdy_val = 1'b1;
        repeat (150) @(negedge clk);
        check("final_idle", busy_o, 0);
        check("final_drained", rx_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
